axil_spram_bridge: RTL and testbench
====================================

Name: axil_spram_bridge

Overview:
- AXI4-Lite-style slave front end (8-bit data lane) that sits directly upstream of multi_bank_spram_32x8.
- Converts AW/W/B and AR/R channel handshakes into the memory's single-port en/we/addr/din strobes, and captures the memory's registered dout into an R response.
- Serialises reads and writes onto the one memory port, one transaction at a time, with round-robin arbitration.

Parameters:
- ADDR_W, 5, address width; matches the 32-entry memory.
- DATA_W, 8, data width of the W/R channels and the memory.
- MEM_RD_LAT, 1, number of clk edges from a sampled read strobe until mem_dout is valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  1  byte strobe; 0 means no memory write.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response; always 2'b00 (OKAY).
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_W  read address.
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response; always 2'b00.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- mem_en  out  1  memory enable, driven to the SPRAM en.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, registered inside the SPRAM.

Behaviour:
- FSM states: IDLE, WR, WRESP, RD, RWAIT, RRESP. On reset, state = IDLE.
- Reset values:
  - All ready and valid outputs = 0.
  - mem_en, mem_we = 0.
  - mem_addr, mem_din, s_rdata = 0.
  - last_grant = WRITE, so a read wins the first collision.
- Ready signals:
  - s_awready = s_wready = (IDLE and write granted), combinational.
  - s_arready = (IDLE and read granted), combinational.
  - A write request requires s_awvalid and s_wvalid together. AW alone or W alone is never accepted, and the corresponding ready stays 0.
- Arbitration in IDLE:
  - Only write pending: grant write.
  - Only read pending: grant read.
  - Both pending: grant the channel opposite last_grant.
  - last_grant updates on every accepted transaction.
- Write path:
  - On the accepting edge, register the address and data, and register the strobe as we_q = s_wstrb. Go to WR.
  - WR: drive mem_en = 1, mem_we = we_q, mem_addr and mem_din from the registers, for exactly one cycle. Go to WRESP.
  - WRESP: s_bvalid = 1 and s_bresp = 0, held stable until s_bready is sampled high. Then go to IDLE.
  - s_bvalid first rises 2 cycles after the handshake cycle.
- Read path:
  - On the accepting edge, register the address. Go to RD.
  - RD: mem_en = 1, mem_we = 0 for exactly one cycle. Go to RWAIT.
  - RWAIT: hold for MEM_RD_LAT cycles, driving mem_en = 0. Sample mem_dout into s_rdata on the last RWAIT edge. Go to RRESP.
  - RRESP: s_rvalid = 1 with s_rdata stable until s_rready is high, then go to IDLE.
  - With MEM_RD_LAT = 1, s_rvalid first rises 3 cycles after the AR handshake cycle.
- mem_en is 0 in every state except WR and RD. mem_addr and mem_din hold their last values when idle.
- No new request is accepted in WR, WRESP, RD, RWAIT or RRESP. The earliest next accept is the IDLE cycle after the response handshake.
- A response handshake in the same cycle as valid rising is legal, provided ready was already high.
- s_wstrb = 0: no memory write (mem_we = 0 in WR), but the bridge still passes through WR, and B still returns OKAY.
- Reset mid-operation:
  - Abort immediately to IDLE and drop any pending B or R response.
  - mem_en = 0 in the cycle after the reset edge, so no partial memory access completes.
- A request held valid across reset is accepted on the first IDLE cycle after rst falls.

Test Plan:
- Single write then read: AW = 5'd3 and W = 8'hA5 together, bready = 1 → mem_en = mem_we = 1 for one cycle with addr 3 and din A5. bvalid rises 2 cycles after the handshake, bresp = 0. Then AR = 3 → rvalid rises 3 cycles later with rdata = 8'hA5.
- Full sweep: write data = addr ^ 8'h5A to all 32 addresses, then read addresses 0..31 → every rdata matches. Addresses 0 and 31 (wrap boundary) are checked explicitly.
- Collision: AW/W (addr 7, 8'h11) and AR (addr 7) asserted together straight after reset → read granted first (returns prior contents). Write is granted next. A second collision then grants write first.
- Backpressure: bready = 0 for 5 cycles, then rready = 0 for 5 cycles → bvalid/rvalid stay high with stable bresp/rdata. There are no further mem_en pulses, and awready/arready stay 0 throughout.
- Strobe off: write addr 9 with wstrb = 0 and data 8'hFF over prior contents 8'h42 → B = OKAY, mem_we = 0, and a read of addr 9 returns 8'h42.
- Reset mid-read: assert rst in the RWAIT cycle → no rvalid ever appears for that read. All outputs are 0 the next cycle, and a fresh read of the same address completes normally afterward.

Source files
------------

// File: rtl/axil_spram_bridge.sv
// AXI4-Lite (8-bit lane) slave to single-port SPRAM bridge; one transaction in flight, round-robin read/write arbitration.
// Latency: B valid 2 cycles after the AW/W handshake, R valid MEM_RD_LAT+2 cycles after AR; no new accepts until the response handshakes.
module axil_spram_bridge #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_t;

    localparam logic [1:0] RWAIT_LAST = 2'(MEM_RD_LAT - 1);

    state_t            state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;

    logic wr_req, rd_req, grant_wr, grant_rd;

    // A write needs both AW and W; on a collision the channel not served last wins.
    assign wr_req   = s_awvalid & s_wvalid;
    assign rd_req   = s_arvalid;
    assign grant_wr = (state_q == IDLE) && wr_req && (!rd_req || !last_wr_q);
    assign grant_rd = (state_q == IDLE) && rd_req && (!wr_req || last_wr_q);

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;
    assign s_bresp   = 2'b00;
    assign s_bvalid  = bvalid_q;
    assign s_rresp   = 2'b00;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        rdata_d   = rdata_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = WR;
                    last_wr_d = 1'b1;
                    mem_en_d  = 1'b1;
                    mem_we_d  = s_wstrb;
                    addr_d    = s_awaddr;
                    din_d     = s_wdata;
                end else if (grant_rd) begin
                    state_d   = RD;
                    last_wr_d = 1'b0;
                    mem_en_d  = 1'b1;
                    addr_d    = s_araddr;
                end
            end
            WR: begin
                state_d  = WRESP;
                bvalid_d = 1'b1;
            end
            WRESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD: begin
                state_d = RWAIT;
                cnt_d   = 2'd0;
            end
            RWAIT: begin
                // mem_dout becomes valid on the MEM_RD_LAT-th edge after the strobe.
                if (cnt_q == RWAIT_LAST) begin
                    rdata_d  = mem_dout;
                    rvalid_d = 1'b1;
                    state_d  = RRESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RRESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            cnt_q     <= 2'd0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            rdata_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rdata_q   <= rdata_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_axil_spram_bridge.sv
// Bench for axil_spram_bridge: SPRAM model, transaction-timeline reference model checked every cycle, directed and random traffic.
module tb_axil_spram_bridge;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] s_awaddr = '0;
    logic       s_awvalid = 1'b0;
    logic       s_awready;
    logic [7:0] s_wdata = '0;
    logic       s_wstrb = 1'b0;
    logic       s_wvalid = 1'b0;
    logic       s_wready;
    logic [1:0] s_bresp;
    logic       s_bvalid;
    logic       s_bready = 1'b0;
    logic [4:0] s_araddr = '0;
    logic       s_arvalid = 1'b0;
    logic       s_arready;
    logic [7:0] s_rdata;
    logic [1:0] s_rresp;
    logic       s_rvalid;
    logic       s_rready = 1'b0;
    logic       mem_en;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    axil_spram_bridge #(.ADDR_W(5), .DATA_W(8), .MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with a registered read path of LAT edges.
    logic [7:0] ram  [32]  = '{default: 8'h00};
    logic [7:0] pipe [LAT] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_din;
        if (mem_en && !mem_we) pipe[0] <= ram[mem_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[LAT-1];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: a transaction accepted in cycle A strobes memory in A+1,
    // answers B from A+2, or R from A+2+LAT, and frees the port after the response handshake.
    bit         m_busy = 1'b0;
    bit         m_is_wr = 1'b0;
    bit         m_strb = 1'b0;
    bit         m_last_wr = 1'b1;
    int         m_acc = 0;
    logic [4:0] m_addr = '0;
    logic [7:0] m_din = '0;
    logic [7:0] m_exp = '0;
    logic [7:0] m_rdata = '0;
    logic [7:0] shadow [32] = '{default: 8'h00};

    initial begin : monitor
        bit wreq, rreq, gw, gr, en_x, we_x, bv_x, rv_x;
        int k;
        @(posedge clk);
        forever begin
            @(negedge clk);
            wreq = s_awvalid && s_wvalid;
            rreq = s_arvalid;
            gw   = !m_busy && wreq && (!rreq || !m_last_wr);
            gr   = !m_busy && rreq && (!wreq || m_last_wr);
            k    = cyc - m_acc;
            en_x = m_busy && (k == 1);
            we_x = en_x && m_is_wr && m_strb;
            bv_x = m_busy && m_is_wr && (k >= 2);
            rv_x = m_busy && !m_is_wr && (k >= 2 + LAT);
            chk("awready", 32'(s_awready), 32'(gw));
            chk("wready", 32'(s_wready), 32'(gw));
            chk("arready", 32'(s_arready), 32'(gr));
            chk("mem_en", 32'(mem_en), 32'(en_x));
            chk("mem_we", 32'(mem_we), 32'(we_x));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_din", 32'(mem_din), 32'(m_din));
            chk("bvalid", 32'(s_bvalid), 32'(bv_x));
            chk("bresp", 32'(s_bresp), 32'd0);
            chk("rvalid", 32'(s_rvalid), 32'(rv_x));
            chk("rresp", 32'(s_rresp), 32'd0);
            chk("rdata", 32'(s_rdata), 32'(m_rdata));
            if (rst) begin
                m_busy = 1'b0; m_last_wr = 1'b1;
                m_addr = '0; m_din = '0; m_rdata = '0;
            end else if (!m_busy) begin
                if (gw) begin
                    m_busy = 1'b1; m_is_wr = 1'b1; m_acc = cyc; m_last_wr = 1'b1;
                    m_addr = s_awaddr; m_din = s_wdata; m_strb = s_wstrb;
                    if (s_wstrb) shadow[s_awaddr] = s_wdata;
                end else if (gr) begin
                    m_busy = 1'b1; m_is_wr = 1'b0; m_acc = cyc; m_last_wr = 1'b0;
                    m_addr = s_araddr; m_exp = shadow[s_araddr];
                end
            end else begin
                if (!m_is_wr && k == 1 + LAT) m_rdata = m_exp;
                if (bv_x && s_bready) m_busy = 1'b0;
                if (rv_x && s_rready) m_busy = 1'b0;
            end
        end
    end

    task automatic do_wr(input logic [4:0] a, input logic [7:0] d, input logic st, input int bp,
                         output int hs, output int lat, output int vcnt);
        bit ok;
        int first;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = (bp == 0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_awready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("wr_accept", 32'(ok), 32'd1);
        hs = cyc;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        ok = 1'b0; vcnt = 0; first = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_bvalid) begin vcnt++; if (first < 0) first = cyc; end
            if (s_bvalid && s_bready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            if (vcnt >= bp) s_bready = 1'b1;
        end
        chk("wr_bresp_hs", 32'(ok), 32'd1);
        lat = first - hs;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic do_rd(input logic [4:0] a, input int bp,
                         output logic [7:0] data, output int hs, output int lat, output int vcnt);
        bit ok;
        int first;
        s_araddr = a; s_arvalid = 1'b1; s_rready = (bp == 0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_arready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("rd_accept", 32'(ok), 32'd1);
        hs = cyc;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        ok = 1'b0; vcnt = 0; first = -1; data = 'x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_rvalid) begin vcnt++; if (first < 0) first = cyc; end
            if (s_rvalid && s_rready) begin ok = 1'b1; data = s_rdata; break; end
            @(posedge clk); #1;
            if (vcnt >= bp) s_rready = 1'b1;
        end
        chk("rd_rresp_hs", 32'(ok), 32'd1);
        lat = first - hs;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int whs, wlat, wv, rhs, rlat, rv;
        logic [7:0] rd_d;
        bit ok;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_bvalid", 32'(s_bvalid), 32'd0);
        chk("reset_rvalid", 32'(s_rvalid), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Collision straight after reset: read goes first, then write.
        fork
            do_wr(5'd7, 8'h11, 1'b1, 0, whs, wlat, wv);
            do_rd(5'd7, 0, rd_d, rhs, rlat, rv);
        join
        chk("coll1_read_first", 32'(rhs < whs), 32'd1);
        chk("coll1_prior_data", 32'(rd_d), 32'h00);
        chk("coll1_wr_lat", 32'(wlat), 32'd2);
        do_rd(5'd7, 0, rd_d, rhs, rlat, rv);
        chk("coll1_readback", 32'(rd_d), 32'h11);
        // Last grant was a read, so this collision serves the write first.
        fork
            do_wr(5'd7, 8'h22, 1'b1, 0, whs, wlat, wv);
            do_rd(5'd7, 0, rd_d, rhs, rlat, rv);
        join
        chk("coll2_write_first", 32'(whs < rhs), 32'd1);
        chk("coll2_data", 32'(rd_d), 32'h22);

        do_wr(5'd3, 8'hA5, 1'b1, 0, whs, wlat, wv);
        chk("single_b_lat", 32'(wlat), 32'd2);
        do_rd(5'd3, 0, rd_d, rhs, rlat, rv);
        chk("single_r_lat", 32'(rlat), 32'd3);
        chk("single_rdata", 32'(rd_d), 32'hA5);

        do_wr(5'd9, 8'h42, 1'b1, 0, whs, wlat, wv);
        do_wr(5'd9, 8'hFF, 1'b0, 0, whs, wlat, wv);
        do_rd(5'd9, 0, rd_d, rhs, rlat, rv);
        chk("strobe_off_rdata", 32'(rd_d), 32'h42);

        // Backpressure on B, with a read waiting behind it, then on R.
        fork
            do_wr(5'd12, 8'h3C, 1'b1, 5, whs, wlat, wv);
            begin
                @(posedge clk); #1;
                do_rd(5'd12, 5, rd_d, rhs, rlat, rv);
            end
        join
        chk("bp_bvalid_cycles", 32'(wv), 32'd6);
        chk("bp_rvalid_cycles", 32'(rv), 32'd6);
        chk("bp_rdata", 32'(rd_d), 32'h3C);

        for (int a = 0; a < 32; a++)
            do_wr(5'(a), 8'(a) ^ 8'h5A, 1'b1, 0, whs, wlat, wv);
        for (int a = 0; a < 32; a++) begin
            do_rd(5'(a), 0, rd_d, rhs, rlat, rv);
            chk("sweep_rdata", 32'(rd_d), 32'(8'(a) ^ 8'h5A));
        end
        do_rd(5'd0, 0, rd_d, rhs, rlat, rv);
        chk("sweep_addr0", 32'(rd_d), 32'h5A);
        do_rd(5'd31, 0, rd_d, rhs, rlat, rv);
        chk("sweep_addr31", 32'(rd_d), 32'h45);

        // Reset while the read is waiting on the memory.
        s_araddr = 5'd3; s_arvalid = 1'b1; s_rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_arready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("rstmid_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_en", 32'(mem_en), 32'd0);
        chk("rstmid_rvalid", 32'(s_rvalid), 32'd0);
        chk("rstmid_rdata", 32'(s_rdata), 32'd0);
        chk("rstmid_mem_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_no_rvalid", 32'(s_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        s_rready = 1'b0;
        do_rd(5'd3, 0, rd_d, rhs, rlat, rv);
        chk("rstmid_fresh_read", 32'(rd_d), 32'h59);

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            s_awvalid = ($urandom_range(0, 2) != 0);
            s_wvalid  = ($urandom_range(0, 2) != 0);
            s_arvalid = ($urandom_range(0, 2) == 0);
            s_awaddr  = 5'($urandom_range(0, 31));
            s_araddr  = 5'($urandom_range(0, 31));
            s_wdata   = 8'($urandom_range(0, 255));
            s_wstrb   = ($urandom_range(0, 3) != 0);
            s_bready  = ($urandom_range(0, 3) != 0);
            s_rready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1; rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
